fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, 32, instruction and address width in bits.
REQ-002 Parameter RESET_PC, 0, first fetch address after reset.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset=0 at a rising edge resets the block.
REQ-005 stall_id  input  1  ID stage cannot accept an instruction this cycle.
REQ-006 redirect  input  1  taken branch/jump; flush and refetch from redirect_pc.
REQ-007 redirect_pc  input  N  new fetch address, sampled when redirect=1.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  N  byte address of the request.
REQ-010 imem_ack  input  1  read complete; imem_rdata valid in this same cycle.
REQ-011 imem_rdata  input  N  fetched instruction word.
REQ-012 instr_if  output  N  instruction presented to the IF/ID pipeline register.
REQ-013 pc_if  output  N  address of instr_if.
REQ-014 valid_if  output  1  instr_if/pc_if hold a valid instruction.

Function
REQ-015 Block SHALL hold a 2-entry FIFO of {pc, instr}; count in 0..2.
REQ-016 valid_if SHALL equal (count!=0); when count=0, instr_if and pc_if SHALL be 0 (NOP).
REQ-017 Pop SHALL occur when valid_if=1, stall_id=0, redirect=0; head is replaced by next entry in the next cycle.
REQ-018 FSM states: FETCH (normal), DRAIN (discard one outstanding response).
REQ-019 In FETCH, a request SHALL start when imem_req=0 and (count<2 or pop this cycle); imem_req and imem_addr SHALL then stay constant until the cycle with imem_ack=1.
REQ-020 imem_ack=1 in FETCH with redirect=0 SHALL push {imem_addr, imem_rdata} and advance fetch_pc by 4, modulo 2^N.
REQ-021 imem_req SHALL drop in the cycle after the ack unless a new request starts back-to-back per REQ-019.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 With count=2 and no pop, no new request SHALL start; memory stalls (imem_ack=0) SHALL hold all outputs stable.
REQ-024 redirect=1 SHALL, next cycle: clear the FIFO (valid_if=0); set fetch_pc=redirect_pc; discard any same-cycle ack data; suppress pop.
REQ-025 redirect=1 while a request is outstanding and imem_ack=0 SHALL enter DRAIN; in DRAIN, imem_req stays high with the old address, the ack response is discarded, then FETCH resumes with a request at the saved redirect_pc.
REQ-026 redirect=1 in DRAIN SHALL overwrite the saved target; the latest redirect_pc wins.
REQ-027 redirect SHALL take priority over stall_id and pop.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 reset=0 SHALL force: FETCH, count=0, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, valid_if=0, instr_if=0, pc_if=0.
REQ-030 Reset mid-transaction SHALL abandon the request; a late ack after reset release with imem_req=0 is ignored per REQ-028.
REQ-031 The first request (imem_addr=RESET_PC) SHALL assert in the first cycle with reset=1.

Verification
REQ-032 Zero-wait memory, stall_id=0: pc_if sequence 0,4,8,12, instr_if matches memory, one instruction per cycle after first fill.
REQ-033 stall_id=1 for 5 cycles with ack always 1: count saturates at 2, imem_req=0, instr_if held; release resumes in order with no loss or duplication.
REQ-034 redirect to 0x100 with request outstanding, ack 3 cycles later: DRAIN, old data dropped, next request addr 0x100, first valid pc_if=0x100.
REQ-035 redirect and imem_ack in same cycle: ack data discarded, next request addr = redirect_pc, valid_if=0 for the next cycle.
REQ-036 reset=0 asserted while imem_req=1 and FIFO full: next cycle all outputs at reset values; after release first imem_addr=RESET_PC.
REQ-037 fetch_pc=0xFFFFFFFC with ack: next imem_addr=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding memory request feeding a 2-entry
// {pc, instr} FIFO that presents instructions to the IF/ID pipeline register.
module fetch_unit #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall_id,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr_if,
    output logic [N-1:0] pc_if,
    output logic         valid_if,
    output logic         dbg_drain
);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] fetch_pc_q, fetch_pc_d;
    logic         req_q, req_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] pc_q [2];
    logic [N-1:0] pc_d [2];
    logic [N-1:0] instr_q [2];
    logic [N-1:0] instr_d [2];

    logic         pop;
    logic         push;
    logic [1:0]   wr_base;
    logic [1:0]   cnt_after;

    // fetch_pc_q is the address of the next request to issue; in DRAIN it holds
    // the saved redirect target. A request only starts when the FIFO has room for
    // its response, so an ack can never arrive into a full FIFO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        instr_d    = instr_q;

        pop       = (cnt_q != 2'd0) && !stall_id && !redirect;
        push      = (state_q == FETCH) && req_q && imem_ack && !redirect;
        wr_base   = cnt_q - {1'b0, pop};
        cnt_after = cnt_q + {1'b0, push} - {1'b0, pop};

        if (redirect) begin
            cnt_d = 2'd0;
            if (req_q && !imem_ack) begin
                state_d    = DRAIN;
                fetch_pc_d = redirect_pc;
            end else begin
                state_d    = FETCH;
                req_d      = 1'b1;
                addr_d     = redirect_pc;
                fetch_pc_d = redirect_pc + N'(4);
            end
        end else if (state_q == DRAIN) begin
            if (imem_ack) begin
                state_d    = FETCH;
                req_d      = 1'b1;
                addr_d     = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + N'(4);
            end
        end else begin
            if (pop) begin
                pc_d[0]    = pc_q[1];
                instr_d[0] = instr_q[1];
            end
            if (push) begin
                pc_d[wr_base[0]]    = addr_q;
                instr_d[wr_base[0]] = imem_rdata;
            end
            cnt_d = cnt_after;
            if (!req_q || imem_ack) begin
                if (cnt_after < 2'd2) begin
                    req_d      = 1'b1;
                    addr_d     = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + N'(4);
                end else begin
                    req_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= FETCH;
            cnt_q      <= 2'd0;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign valid_if  = (cnt_q != 2'd0);
    assign pc_if     = valid_if ? pc_q[0] : '0;
    assign instr_if  = valid_if ? instr_q[0] : '0;
    assign dbg_drain = (state_q == DRAIN);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences and
// a randomized run checked against an in-order instruction stream model.
module tb_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset, stall_id, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_if, dbg_drain;
    logic [31:0] imem_addr, instr_if, pc_if;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.N(32), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .stall_id(stall_id), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_if(instr_if),
        .pc_if(pc_if), .valid_if(valid_if), .dbg_drain(dbg_drain)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_drain;
    } vec_t;

    vec_t tbl[$];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic r, s, d, input logic [31:0] rp,
                                input logic a, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep,
                                input logic [31:0] ei, input logic edr);
        vec_t v;
        v = '{r, s, d, rp, a, rd, er, ea, ev, ep, ei, edr};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, d, input logic [31:0] rp,
                         input logic a, input logic [31:0] rd);
        reset       = r;
        stall_id    = s;
        redirect    = d;
        redirect_pc = rp;
        imem_ack    = a;
        imem_rdata  = rd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        p_rst, p_redir, p_wait, p_hold;
        logic [31:0] p_addr, p_pc;
        logic        r, s, d, a;
        logic [31:0] rp, rd;
        int          lat, pops;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // rst stall redir rpc  ack rdata | req addr valid pc instr drain
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,          0,32'h0,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,          1,32'h0,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,1,mw(32'h0),      1,32'h4,1,32'h0,mw(32'h0),0));
        tbl.push_back(mk(1,0,0,32'h0,1,mw(32'h4),      1,32'h8,1,32'h4,mw(32'h4),0));
        tbl.push_back(mk(1,1,0,32'h0,1,mw(32'h8),      0,32'h8,1,32'h4,mw(32'h4),0));
        tbl.push_back(mk(1,1,0,32'h0,1,JUNK,           0,32'h8,1,32'h4,mw(32'h4),0));
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,          1,32'hC,1,32'h8,mw(32'h8),0));
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,          1,32'hC,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,          1,32'hC,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,1,mw(32'hC),      1,32'h10,1,32'hC,mw(32'hC),0));
        tbl.push_back(mk(1,0,1,32'h100,1,JUNK,         1,32'h100,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,          1,32'h100,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,1,32'h200,0,32'h0,        1,32'h100,0,32'h0,32'h0,1));
        tbl.push_back(mk(1,0,1,32'h300,0,32'h0,        1,32'h100,0,32'h0,32'h0,1));
        tbl.push_back(mk(1,0,0,32'h0,1,JUNK,           1,32'h300,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,1,mw(32'h300),    1,32'h304,1,32'h300,mw(32'h300),0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,          0,32'h0,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,1,JUNK,           1,32'h0,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,1,32'hFFFF_FFFC,1,JUNK,   1,32'hFFFF_FFFC,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,1,0,32'h0,1,mw(32'hFFFF_FFFC), 1,32'h0,1,32'hFFFF_FFFC,mw(32'hFFFF_FFFC),0));
        tbl.push_back(mk(1,1,0,32'h0,1,mw(32'h0),      0,32'h0,1,32'hFFFF_FFFC,mw(32'hFFFF_FFFC),0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,          0,32'h0,0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,          1,32'h0,0,32'h0,32'h0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].rdata);
            tick();
            chk($sformatf("row%0d req", i),   {31'h0, imem_req},  {31'h0, tbl[i].e_req});
            chk($sformatf("row%0d addr", i),  imem_addr,          tbl[i].e_addr);
            chk($sformatf("row%0d valid", i), {31'h0, valid_if},  {31'h0, tbl[i].e_valid});
            chk($sformatf("row%0d pc", i),    pc_if,              tbl[i].e_pc);
            chk($sformatf("row%0d instr", i), instr_if,           tbl[i].e_instr);
            chk($sformatf("row%0d drain", i), {31'h0, dbg_drain}, {31'h0, tbl[i].e_drain});
        end

        // Redirect with a request outstanding; its ack lands three cycles later.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        chk("drain_enter", {31'h0, dbg_drain}, 32'h1);
        chk("drain_addr_hold", imem_addr, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, mw(32'h0));
        tick();
        chk("drain_exit", {31'h0, dbg_drain}, 32'h0);
        chk("drain_new_addr", imem_addr, 32'h100);
        chk("drain_dropped", {31'h0, valid_if}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, mw(32'h100));
        tick();
        chk("drain_first_pc", pc_if, 32'h100);
        chk("drain_first_instr", instr_if, mw(32'h100));

        // Zero-wait memory, ID stalled for 5 cycles: stream must stay in order.
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 12; k++) exp_q.push_back(32'(k * 4));
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            s = (c >= 4 && c < 9);
            if (c == 9) begin
                chk("stall_req_low", {31'h0, imem_req}, 32'h0);
                chk("stall_pc_held", pc_if, 32'h8);
            end
            if (valid_if && !s) chk("stall_order", pc_if, exp_q.pop_front());
            drive(1'b1, s, 1'b0, 32'h0, 1'b1, imem_req ? mw(imem_addr) : JUNK);
            tick();
        end
        chk("stall_stream_done", 32'(exp_q.size()), 32'h0);

        // Randomized run against an in-order stream model.
        do_reset();
        exp_pc = RPC;
        p_rst = 1'b0; p_redir = 1'b0; p_wait = 1'b0; p_hold = 1'b0;
        p_addr = '0; p_pc = '0;
        lat = 0;
        pops = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!p_rst) begin
                chk("rnd_reset_req", {31'h0, imem_req}, 32'h0);
                chk("rnd_reset_valid", {31'h0, valid_if}, 32'h0);
            end else if (p_redir) begin
                chk("rnd_redirect_flush", {31'h0, valid_if}, 32'h0);
            end
            if (p_rst && p_wait) begin
                chk("rnd_req_hold", {31'h0, imem_req}, 32'h1);
                chk("rnd_addr_hold", imem_addr, p_addr);
            end
            if (p_rst && p_hold) chk("rnd_stall_hold", pc_if, p_pc);
            if (!valid_if) chk("rnd_nop", pc_if | instr_if, 32'h0);

            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 99) < 30);
            d  = ($urandom_range(0, 99) < 5);
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            if (imem_req) begin
                if (lat == 0) begin
                    a   = 1'b1;
                    rd  = mw(imem_addr);
                    lat = $urandom_range(0, 3);
                end else begin
                    a   = 1'b0;
                    rd  = JUNK;
                    lat = lat - 1;
                end
            end else begin
                a  = ($urandom_range(0, 9) == 0);
                rd = JUNK;
            end

            if (!r) begin
                exp_pc = RPC;
            end else if (d) begin
                exp_pc = rp;
            end else if (valid_if && !s) begin
                chk("rnd_pc", pc_if, exp_pc);
                chk("rnd_instr", instr_if, mw(exp_pc));
                exp_pc = exp_pc + 32'h4;
                pops++;
            end

            p_rst   = r;
            p_redir = d;
            p_wait  = imem_req && !a;
            p_addr  = imem_addr;
            p_hold  = valid_if && s && !d;
            p_pc    = pc_if;
            drive(r, s, d, rp, a, rd);
            tick();
        end
        chk("rnd_progress", {31'h0, pops >= 300}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
